alu_issue_ctrl: RTL and testbench

Command issue and result-capture stage directly upstream of the 8-bit `ALU`. It accepts `{op, A, B}` commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's `instruction`/`inputA`/`inputB` one command at a time, holding them stable for a fixed settle latency. It then samples `alu_out` and returns the result over a second valid/ready interface. It replaces bench-style "drive, wait, check" sequencing with a reusable hardware stage.

---
 rtl/alu_issue_ctrl_if.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command and result handshake bundle for alu_issue_ctrl
//
// Ports carried:
//   cmd_valid/cmd_ready   command handshake (producer -> alu_issue_ctrl)
//   cmd_op[3:0]           opcode
//   cmd_a[7:0],cmd_b[7:0] operands
//   res_valid/res_ready   result handshake (alu_issue_ctrl -> consumer)
//   res_data[7:0]         captured ALU result (8'h00 for illegal opcodes)
//   res_op[3:0]           opcode the result belongs to
//   res_illegal           result is for an illegal opcode
// master: the producer/consumer side; slave: alu_issue_ctrl.

interface alu_issue_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_op;
   logic       res_illegal;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data, res_op, res_illegal
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data, res_op, res_illegal
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO, ALU operand issue and result capture stage
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-low
//   bus (slave)         command and result handshakes, see alu_issue_ctrl_if
//   alu_instruction     opcode driven to the ALU, held between commands
//   alu_inputA/B        operands driven to the ALU, held between commands
//   alu_out             ALU result, sampled ALU_LAT cycles after operands load
//   busy                FSM not idle or FIFO not empty
//   err_count           saturating illegal-opcode count
// Parameters: FIFO_DEPTH (power of two, >= 2), ALU_LAT (>= 1).
// Optional feature: define ALU_ISSUE_ERRCNT_EN to build the illegal-opcode
// counter; otherwise err_count is tied to 8'h00.

module alu_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   alu_issue_ctrl_if.slave   bus,
   output logic [3:0]        alu_instruction,
   output logic [7:0]        alu_inputA,
   output logic [7:0]        alu_inputB,
   input  logic [7:0]        alu_out,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // FIFO entry layout: {op[3:0], a[7:0], b[7:0]}
   logic [19:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty, push, pop;
   logic [19:0]      head;
   logic [3:0]       head_op;
   logic             head_legal;

   logic [CNT_W-1:0] wait_cnt;
   logic             load_alu, take_illegal, take_result;

   logic [7:0]       res_data_q;
   logic [3:0]       res_op_q;
   logic             res_illegal_q;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   // Gated by reset so the producer sees "not ready" for the whole reset window.
   assign bus.cmd_ready = !full && reset;
   assign push       = bus.cmd_valid && bus.cmd_ready;
   assign head       = fifo_mem[rd_ptr];
   assign head_op    = head[19:16];
   assign head_legal = (head_op <= 4'd5);

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
      end
   end

   // count is registered, so a pop cannot raise cmd_ready in its own cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      load_alu     = 1'b0;
      take_illegal = 1'b0;
      take_result  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_legal) begin
                  load_alu = 1'b1;
                  state_d  = S_WAIT;
               end else begin
                  take_illegal = 1'b1;
                  state_d      = S_RESULT;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == LAT_LAST) begin
               take_result = 1'b1;
               state_d     = S_RESULT;
            end
         end
         S_RESULT: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU operand registers change only on a legal pop, so they stay frozen
   // through WAIT and across illegal commands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alu_instruction <= 4'h0;
         alu_inputA      <= 8'h00;
         alu_inputB      <= 8'h00;
         wait_cnt        <= '0;
         res_data_q      <= 8'h00;
         res_op_q        <= 4'h0;
         res_illegal_q   <= 1'b0;
      end else begin
         if (load_alu) begin
            alu_instruction <= head_op;
            alu_inputA      <= head[15:8];
            alu_inputB      <= head[7:0];
            wait_cnt        <= '0;
         end else if (state_q == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (take_illegal) begin
            res_data_q    <= 8'h00;
            res_op_q      <= head_op;
            res_illegal_q <= 1'b1;
         end else if (take_result) begin
            res_data_q    <= alu_out;
            res_op_q      <= alu_instruction;
            res_illegal_q <= 1'b0;
         end
      end
   end

   assign bus.res_valid   = (state_q == S_RESULT);
   assign bus.res_data    = res_data_q;
   assign bus.res_op      = res_op_q;
   assign bus.res_illegal = res_illegal_q;
   assign busy            = (state_q != S_IDLE) || !empty;

`ifdef ALU_ISSUE_ERRCNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 8'h00;
      end else if (take_illegal && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;
   localparam int FIFO_DEPTH = 4;
   localparam int ALU_LAT    = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] alu_instruction;
   logic [7:0] alu_inputA, alu_inputB, alu_out, err_count;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .alu_instruction (alu_instruction),
      .alu_inputA      (alu_inputA),
      .alu_inputB      (alu_inputB),
      .alu_out         (alu_out),
      .busy            (busy),
      .err_count       (err_count)
   );

   // ALU stand-in: output is garbage (8'hEE) until operands have been stable
   // across one clock edge, so a premature sample is visible.
   logic [19:0] alu_prev;
   always @(posedge clk) alu_prev <= {alu_instruction, alu_inputA, alu_inputB};
   always_comb begin
      alu_out = 8'hEE;
      if ({alu_instruction, alu_inputA, alu_inputB} == alu_prev) begin
         case (alu_instruction)
            4'd0:    alu_out = alu_inputA + alu_inputB;
            4'd1:    alu_out = alu_inputA - alu_inputB;
            4'd2:    alu_out = ~alu_inputB;
            4'd3:    alu_out = alu_inputA & alu_inputB;
            4'd4:    alu_out = alu_inputA | alu_inputB;
            4'd5:    alu_out = alu_inputA ^ alu_inputB;
            default: alu_out = 8'h00;
         endcase
      end
   end

   // Reference: expected {illegal, op, data} for a command.
   function automatic logic [12:0] ref_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int ia, ib, r;
      ia = a; ib = b;
      case (op)
         4'd0: r = (ia + ib) % 256;
         4'd1: r = (ia - ib + 256) % 256;
         4'd2: r = 255 - ib;
         4'd3: r = ia & ib;
         4'd4: r = ia | ib;
         4'd5: r = ia ^ ib;
         default: return {1'b1, op, 8'h00};
      endcase
      return {1'b0, op, 8'(r)};
   endfunction

   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];
   int          err_exp = 0;

   always @(posedge clk) begin
      if (!reset) begin
         exp_q.delete();
         err_exp = 0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            exp_q.push_back(ref_result(bus.cmd_op, bus.cmd_a, bus.cmd_b));
            if (bus.cmd_op > 4'd5 && err_exp < 255) err_exp++;
         end
         if (bus.res_valid && bus.res_ready)
            obs_q.push_back({bus.res_illegal, bus.res_op, bus.res_data});
      end
   end

   function automatic logic [7:0] exp_err();
`ifdef ALU_ISSUE_ERRCNT_EN
      return 8'(err_exp);
`else
      return 8'h00;
`endif
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int t;
      bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
      t = 0;
      while (!bus.cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles, required 1", t);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      int t;
      t = 0;
      while (obs_q.size() < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 0", bus.cmd_ready); end
      n_tests++;
      if ({alu_instruction, alu_inputA, alu_inputB} !== 20'h0) begin
         n_fail++; $display("FAIL reset_alu: got %h required 0", {alu_instruction, alu_inputA, alu_inputB});
      end
      n_tests++;
      if ({bus.res_valid, bus.res_data, bus.res_op, bus.res_illegal, err_count, busy} !== 23'h0) begin
         n_fail++; $display("FAIL reset_outputs: got %h required 0",
                            {bus.res_valid, bus.res_data, bus.res_op, bus.res_illegal, err_count, busy});
      end
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL release_ready_busy: got ready=%b busy=%b required 1 0", bus.cmd_ready, busy);
      end
   endtask

   task automatic test_add();
      int cyc;
      exp_q.delete(); obs_q.delete();
      bus.res_ready = 1'b1;
      send_cmd(4'd0, 8'hF0, 8'h20);
      cyc = 0;
      while (!bus.res_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (cyc != ALU_LAT + 1) begin n_fail++; $display("FAIL add_latency: got %0d required %0d", cyc, ALU_LAT + 1); end
      n_tests++;
      if ({bus.res_illegal, bus.res_op, bus.res_data} !== {1'b0, 4'd0, 8'h10}) begin
         n_fail++; $display("FAIL add_result: got %h required %h", {bus.res_illegal, bus.res_op, bus.res_data}, {1'b0, 4'd0, 8'h10});
      end
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_handshake: res_valid got %b required 0", bus.res_valid); end
   endtask

   task automatic test_sub_not();
      exp_q.delete(); obs_q.delete();
      bus.res_ready = 1'b1;
      send_cmd(4'd1, 8'h05, 8'h07);
      send_cmd(4'd2, 8'h99, 8'h3C);
      wait_obs(2);
      n_tests++;
      if (obs_q.size() != 2) begin
         n_fail++; $display("FAIL sub_not_count: got %0d required 2", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== {1'b0, 4'd1, 8'hFE}) begin n_fail++; $display("FAIL sub_result: got %h required %h", obs_q[0], {1'b0, 4'd1, 8'hFE}); end
         n_tests++;
         if (obs_q[1] !== {1'b0, 4'd2, 8'hC3}) begin n_fail++; $display("FAIL not_result: got %h required %h", obs_q[1], {1'b0, 4'd2, 8'hC3}); end
      end
   endtask

   task automatic test_backpressure();
      int         accepted;
      logic       last_ready;
      logic [12:0] held;
      exp_q.delete(); obs_q.delete();
      bus.res_ready = 1'b0;
      accepted = 0;
      last_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.cmd_op = 4'($urandom_range(0, 5));
         bus.cmd_a  = 8'($urandom);
         bus.cmd_b  = 8'($urandom);
         bus.cmd_valid = 1'b1;
         last_ready = bus.cmd_ready;
         if (bus.cmd_ready) accepted++;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      n_tests++;
      if (accepted != FIFO_DEPTH + 1 || last_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_accepted: got %0d (last ready %b) required %0d (last ready 0)", accepted, last_ready, FIFO_DEPTH + 1);
      end
      n_tests++;
      if (bus.cmd_ready !== 1'b0 || busy !== 1'b1 || bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_stall: got ready=%b busy=%b valid=%b required 0 1 1", bus.cmd_ready, busy, bus.res_valid);
      end
      held = {bus.res_illegal, bus.res_op, bus.res_data};
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.res_illegal, bus.res_op, bus.res_data} !== held || bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold: got %h valid=%b required %h valid=1", {bus.res_illegal, bus.res_op, bus.res_data}, bus.res_valid, held);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_handshake: got %b required 0", bus.cmd_ready); end
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b required 1", bus.cmd_ready); end
      wait_obs(accepted);
      n_tests++;
      if (obs_q.size() != exp_q.size() || obs_q.size() != FIFO_DEPTH + 1) begin
         n_fail++; $display("FAIL bp_count: got %0d results, model %0d, required %0d", obs_q.size(), exp_q.size(), FIFO_DEPTH + 1);
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_illegal();
      int         cyc;
      logic [3:0] prev_ins;
      exp_q.delete(); obs_q.delete();
      bus.res_ready = 1'b1;
      repeat (2) @(negedge clk);
      prev_ins = alu_instruction;
      send_cmd(4'h9, 8'($urandom), 8'($urandom));
      cyc = 0;
      while (!bus.res_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (cyc != 1) begin n_fail++; $display("FAIL illegal_latency: got %0d required 1", cyc); end
      n_tests++;
      if ({bus.res_illegal, bus.res_op, bus.res_data} !== {1'b1, 4'h9, 8'h00}) begin
         n_fail++; $display("FAIL illegal_result: got %h required %h", {bus.res_illegal, bus.res_op, bus.res_data}, {1'b1, 4'h9, 8'h00});
      end
      n_tests++;
      if (alu_instruction !== prev_ins) begin n_fail++; $display("FAIL illegal_alu_hold: got %h required %h", alu_instruction, prev_ins); end
      n_tests++;
      if (err_count !== exp_err()) begin n_fail++; $display("FAIL illegal_err_count: got %0d required %0d", err_count, exp_err()); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int t;
      exp_q.delete(); obs_q.delete();
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [3:0] op;
               op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
               send_cmd(op, 8'($urandom), 8'($urandom));
            end
         end
         begin
            t = 0;
            while (obs_q.size() < 40 && t < 5000) begin
               bus.res_ready = ($urandom_range(0, 2) != 0);
               @(negedge clk);
               t++;
            end
         end
      join
      bus.res_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs_q.size() != 40 || exp_q.size() != 40) begin
         n_fail++; $display("FAIL rand_count: got %0d results, model %0d, required 40", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 40; i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
         end
      end
      n_tests++;
      if (err_count !== exp_err()) begin n_fail++; $display("FAIL rand_err_count: got %0d required %0d", err_count, exp_err()); end
   endtask

   task automatic test_reset_wait();
      int seen;
      exp_q.delete(); obs_q.delete();
      bus.res_ready = 1'b1;
      send_cmd(4'd0, 8'h11, 8'h22);
      send_cmd(4'd3, 8'hF0, 8'h3C);
      send_cmd(4'd5, 8'hAA, 8'h55);
      reset = 1'b0;
      obs_q.delete();
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen++;
      end
      n_tests++;
      if (seen != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL rstwait_no_result: got valid cycles=%0d results=%0d required 0 0", seen, obs_q.size());
      end
      n_tests++;
      if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstwait_idle: got busy=%b ready=%b required 0 1", busy, bus.cmd_ready);
      end
      n_tests++;
      if ({alu_instruction, alu_inputA, alu_inputB, err_count} !== 28'h0) begin
         n_fail++; $display("FAIL rstwait_regs: got %h required 0", {alu_instruction, alu_inputA, alu_inputB, err_count});
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'h0;
      bus.cmd_a     = 8'h00;
      bus.cmd_b     = 8'h00;
      bus.res_ready = 1'b0;
      reset         = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_sub_not();
      test_backpressure();
      test_illegal();
      test_random();
      test_reset_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
